// File: rtl/forest_pkg.sv
// Shared types and sizing helpers for the forest inference path: FSM states, default
// dimensions and the tree node record used by the engine and the node-memory loader.
package forest_pkg;

  localparam int unsigned DEFAULT_N_TREES = 64;
  localparam int unsigned DEFAULT_LEAF_W  = 32;
  localparam int unsigned NODE_IDX_W      = 8;
  localparam int unsigned FEAT_IDX_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESULT
  } forest_state_t;

  typedef struct packed {
    logic signed [DEFAULT_LEAF_W-1:0] value;
    logic [NODE_IDX_W-1:0]            right_child;
    logic [FEAT_IDX_W-1:0]            feature;
    logic                             leaf;
  } tree_node_t;

  // Wide enough that summing n_trees full-scale leaves can never wrap.
  function automatic int unsigned sum_width(input int unsigned n_trees,
                                            input int unsigned leaf_w);
    return leaf_w + int'($clog2(n_trees)) + 1;
  endfunction

endpackage

// File: rtl/forest_accumulator_if.sv
// Bundles the host command, tree-engine launch/done and result handshake signals
// of the forest accumulator.
interface forest_accumulator_if
  import forest_pkg::*;
#(
  parameter int unsigned N_TREES = DEFAULT_N_TREES,
  parameter int unsigned LEAF_W  = DEFAULT_LEAF_W,
  parameter int unsigned SUM_W   = sum_width(N_TREES, LEAF_W)
) ();

  logic                         start;
  logic [$clog2(N_TREES+1)-1:0] n_trees;
  logic signed [SUM_W-1:0]      threshold;

  logic                         tree_start;
  logic [$clog2(N_TREES)-1:0]   tree_index;
  logic                         tree_done;
  logic signed [LEAF_W-1:0]     leaf_value;

  logic                         busy;
  logic                         result_valid;
  logic                         result_ready;
  logic signed [SUM_W-1:0]      score;
  logic                         prediction;

  modport master (
    output start, n_trees, threshold, tree_done, leaf_value, result_ready,
    input  tree_start, tree_index, busy, result_valid, score, prediction
  );

  modport slave (
    input  start, n_trees, threshold, tree_done, leaf_value, result_ready,
    output tree_start, tree_index, busy, result_valid, score, prediction
  );

endinterface

// File: rtl/forest_accumulator.sv
// Sequences the tree engine over n_trees trees, sums their leaf values and returns the
// ensemble score plus a thresholded prediction over a valid/ready handshake.
module forest_accumulator
  import forest_pkg::*;
#(
  parameter int unsigned N_TREES = DEFAULT_N_TREES,
  parameter int unsigned LEAF_W  = DEFAULT_LEAF_W,
  parameter int unsigned SUM_W   = sum_width(N_TREES, LEAF_W)
) (
  input logic                 clk,
  input logic                 rst_n,
  forest_accumulator_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(N_TREES + 1);
  localparam int unsigned IDX_W = $clog2(N_TREES);

  forest_state_t           state_q, state_d;
  logic [CNT_W-1:0]        n_eff_q, n_eff_d;
  logic signed [SUM_W-1:0] thr_q, thr_d;
  logic signed [SUM_W-1:0] score_q, score_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tree_start_q, tree_start_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    pred_q, pred_d;

  logic [CNT_W-1:0]        n_req;
  logic                    last_tree;
  logic signed [SUM_W-1:0] leaf_ext;

  assign n_req     = (bus.n_trees > CNT_W'(N_TREES)) ? CNT_W'(N_TREES) : bus.n_trees;
  assign last_tree = (CNT_W'(idx_q) == (n_eff_q - CNT_W'(1)));
  assign leaf_ext  = {{(SUM_W - LEAF_W){bus.leaf_value[LEAF_W-1]}}, bus.leaf_value};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_eff_q      <= '0;
      thr_q        <= '0;
      score_q      <= '0;
      idx_q        <= '0;
      tree_start_q <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      pred_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_eff_q      <= n_eff_d;
      thr_q        <= thr_d;
      score_q      <= score_d;
      idx_q        <= idx_d;
      tree_start_q <= tree_start_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      pred_q       <= pred_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (n_req == '0) ? RESULT : LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (bus.tree_done) state_d = last_tree ? RESULT : LAUNCH;
      RESULT:  if (bus.result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    n_eff_d = n_eff_q;
    thr_d   = thr_q;
    score_d = score_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_eff_d = n_req;
          thr_d   = bus.threshold;
          score_d = '0;
          idx_d   = '0;
        end
      end
      WAIT: begin
        if (bus.tree_done) begin
          score_d = score_q + leaf_ext;
          if (!last_tree) idx_d = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
    tree_start_d = (state_d == LAUNCH);
    busy_d       = (state_d != IDLE);
    valid_d      = (state_d == RESULT);
    // Decide once on entry to RESULT, then hold until the next run completes.
    pred_d       = ((state_d == RESULT) && (state_q != RESULT)) ? (score_d >= thr_d) : pred_q;
  end

  assign bus.tree_start   = tree_start_q;
  assign bus.tree_index   = idx_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = valid_q;
  assign bus.score        = score_q;
  assign bus.prediction   = pred_q;

endmodule

// File: tb/tb_forest_accumulator.sv
// Self-checking bench for forest_accumulator: behavioural tree engine plus a sum-of-leaves
// reference model, driven with directed and randomized runs.
module tb_forest_accumulator;
  import forest_pkg::*;

  localparam int unsigned N_TREES = DEFAULT_N_TREES;
  localparam int unsigned LEAF_W  = DEFAULT_LEAF_W;
  localparam int unsigned SUM_W   = sum_width(N_TREES, LEAF_W);
  localparam int unsigned CNT_W   = $clog2(N_TREES + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  forest_accumulator_if #(.N_TREES(N_TREES), .LEAF_W(LEAF_W), .SUM_W(SUM_W)) bus ();

  forest_accumulator #(.N_TREES(N_TREES), .LEAF_W(LEAF_W), .SUM_W(SUM_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic signed [LEAF_W-1:0] leaf_mem [N_TREES];
  int   launch_log [$];
  int   eng_lat = 4;
  logic eng_done = 1'b0;
  logic inj_done = 1'b0;
  logic signed [LEAF_W-1:0] eng_leaf = '0;
  logic signed [LEAF_W-1:0] inj_leaf = '0;

  assign bus.tree_done  = eng_done | inj_done;
  assign bus.leaf_value = inj_done ? inj_leaf : eng_leaf;

  // Behavioural tree engine: leaf for tree i is leaf_mem[i], done eng_lat cycles after launch.
  initial begin : engine
    int idx;
    bit aborted;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (rst_n && bus.tree_start) begin
        idx = int'(bus.tree_index);
        launch_log.push_back(idx);
        aborted = 1'b0;
        for (int k = 0; k < eng_lat; k++) begin
          @(negedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted && rst_n) begin
          eng_leaf = leaf_mem[idx];
          eng_done = 1'b1;
        end
      end
    end
  end

  function automatic int n_eff_of(input int n);
    return (n > int'(N_TREES)) ? int'(N_TREES) : n;
  endfunction

  function automatic longint model_score(input int n);
    longint s = 0;
    for (int i = 0; i < n_eff_of(n); i++) s += longint'(leaf_mem[i]);
    return s;
  endfunction

  task automatic do_start(input int n, input longint thr);
    @(negedge clk);
    launch_log.delete();
    bus.start     = 1'b1;
    bus.n_trees   = n[CNT_W-1:0];
    bus.threshold = thr[SUM_W-1:0];
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_result(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (bus.result_valid === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept();
    @(negedge clk);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (bus.tree_start !== 1'b0) begin n_err++; $display("FAIL rst_tree_start: got %b, expected 0", bus.tree_start); end
    n_vec++; if (bus.tree_index !== '0) begin n_err++; $display("FAIL rst_tree_index: got %0d, expected 0", bus.tree_index); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b, expected 0", bus.busy); end
    n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, expected 0", bus.result_valid); end
    n_vec++; if (bus.score !== '0) begin n_err++; $display("FAIL rst_score: got %0d, expected 0", bus.score); end
    n_vec++; if (bus.prediction !== 1'b0) begin n_err++; $display("FAIL rst_pred: got %b, expected 0", bus.prediction); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit to;
    bit seq_ok;
    eng_lat = 4;
    leaf_mem[0] = 32'sd5; leaf_mem[1] = -32'sd3; leaf_mem[2] = 32'sd10;
    do_start(3, 10);
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b, expected 1", bus.busy); end
    wait_result(to);
    n_vec++; if (to) begin n_err++; $display("FAIL basic_timeout: got no result_valid, expected one"); end
    seq_ok = (launch_log.size() == 3);
    for (int i = 0; i < launch_log.size(); i++) if (launch_log[i] != i) seq_ok = 1'b0;
    n_vec++; if (!seq_ok) begin n_err++; $display("FAIL basic_launches: got %0d launches, expected 0,1,2", launch_log.size()); end
    n_vec++; if (longint'(bus.score) != 12) begin n_err++; $display("FAIL basic_score: got %0d, expected 12", bus.score); end
    n_vec++; if (bus.prediction !== 1'b1) begin n_err++; $display("FAIL basic_pred: got %b, expected 1", bus.prediction); end
    repeat (5) begin
      @(negedge clk);
      n_vec++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL basic_hold: got valid %b, expected 1", bus.result_valid); end
    end
    accept();
    n_vec++; if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_accept: got busy %b valid %b, expected 0 0", bus.busy, bus.result_valid); end
  endtask

  task automatic test_negative();
    bit to;
    eng_lat = 3;
    leaf_mem[0] = -32'sd7; leaf_mem[1] = -32'sd1;
    do_start(2, 0);
    // A stray done during LAUNCH must not be summed.
    if (bus.tree_start === 1'b1) begin
      inj_leaf = 32'sd100;
      inj_done = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
    end
    wait_result(to);
    n_vec++; if (to) begin n_err++; $display("FAIL neg_timeout: got no result_valid, expected one"); end
    n_vec++; if (longint'(bus.score) != -8) begin n_err++; $display("FAIL neg_score: got %0d, expected -8", bus.score); end
    n_vec++; if (bus.prediction !== 1'b0) begin n_err++; $display("FAIL neg_pred: got %b, expected 0", bus.prediction); end
    accept();
  endtask

  task automatic test_zero();
    bit to;
    do_start(0, 0);
    n_vec++; if (bus.result_valid !== 1'b1) begin n_err++; $display("FAIL zero_valid: got %b, expected 1", bus.result_valid); end
    n_vec++; if (bus.tree_start !== 1'b0) begin n_err++; $display("FAIL zero_tree_start: got %b, expected 0", bus.tree_start); end
    wait_result(to);
    n_vec++; if (bus.score !== '0) begin n_err++; $display("FAIL zero_score: got %0d, expected 0", bus.score); end
    n_vec++; if (bus.prediction !== 1'b1) begin n_err++; $display("FAIL zero_pred: got %b, expected 1", bus.prediction); end
    n_vec++; if (launch_log.size() != 0) begin n_err++; $display("FAIL zero_launches: got %0d, expected 0", launch_log.size()); end
    accept();
  endtask

  task automatic test_saturate();
    bit to;
    longint exp_s;
    eng_lat = 1;
    for (int i = 0; i < int'(N_TREES); i++) leaf_mem[i] = 32'sh7FFF_FFFF;
    exp_s = longint'(N_TREES) * 64'sd2147483647;
    do_start(int'(N_TREES) + 5, 0);
    wait_result(to);
    n_vec++; if (to) begin n_err++; $display("FAIL sat_timeout: got no result_valid, expected one"); end
    n_vec++; if (launch_log.size() != int'(N_TREES)) begin
      n_err++; $display("FAIL sat_launches: got %0d, expected %0d", launch_log.size(), N_TREES); end
    n_vec++; if (longint'(bus.score) != exp_s) begin n_err++; $display("FAIL sat_score: got %0d, expected %0d", bus.score, exp_s); end
    n_vec++; if (int'(bus.tree_index) != int'(N_TREES) - 1) begin
      n_err++; $display("FAIL sat_index: got %0d, expected %0d", bus.tree_index, N_TREES - 1); end
    accept();
  endtask

  task automatic test_backpressure();
    bit to;
    int n;
    longint exp_s, thr;
    bit exp_p;
    eng_lat = 2;
    n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) leaf_mem[i] = $urandom;
    exp_s = model_score(n);
    thr = exp_s + longint'($urandom_range(0, 20)) - 10;
    exp_p = (exp_s >= thr);
    do_start(n, thr);
    wait_result(to);
    n_vec++; if (to) begin n_err++; $display("FAIL bp_timeout: got no result_valid, expected one"); end
    for (int c = 0; c < 20; c++) begin
      bus.start = c[0];
      bus.n_trees = CNT_W'(3);
      @(negedge clk);
      n_vec++;
      if (bus.result_valid !== 1'b1 || longint'(bus.score) != exp_s || bus.prediction !== exp_p) begin
        n_err++; $display("FAIL bp_stable: got valid %b score %0d pred %b, expected 1 %0d %b",
                          bus.result_valid, bus.score, bus.prediction, exp_s, exp_p);
      end
    end
    // start coincident with the accepting handshake is still ignored
    bus.start = 1'b1;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.result_ready = 1'b0;
    n_vec++; if (bus.busy !== 1'b0 || bus.tree_start !== 1'b0) begin
      n_err++; $display("FAIL bp_start_ignored: got busy %b tree_start %b, expected 0 0", bus.busy, bus.tree_start); end
    n_vec++; if (longint'(bus.score) != exp_s) begin n_err++; $display("FAIL bp_score_kept: got %0d, expected %0d", bus.score, exp_s); end
    leaf_mem[0] = $urandom;
    do_start(1, 0);
    n_vec++; if (bus.score !== '0) begin n_err++; $display("FAIL bp_score_clear: got %0d, expected 0", bus.score); end
    wait_result(to);
    n_vec++; if (longint'(bus.score) != model_score(1)) begin
      n_err++; $display("FAIL bp_new_score: got %0d, expected %0d", bus.score, model_score(1)); end
    accept();
  endtask

  task automatic test_reset_mid();
    bit to;
    bit reached;
    eng_lat = 6;
    for (int i = 0; i < 4; i++) leaf_mem[i] = $urandom;
    do_start(4, 0);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (launch_log.size() >= 3) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_vec++; if (!reached) begin n_err++; $display("FAIL mid_progress: got %0d launches, expected 3", launch_log.size()); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.tree_start !== 1'b0 || bus.tree_index !== '0 ||
        bus.result_valid !== 1'b0 || bus.score !== '0 || bus.prediction !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got busy %b start %b idx %0d valid %b score %0d pred %b, expected all 0",
                        bus.busy, bus.tree_start, bus.tree_index, bus.result_valid, bus.score, bus.prediction);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    eng_lat = 3;
    leaf_mem[0] = $urandom;
    do_start(1, model_score(1) + 1);
    wait_result(to);
    n_vec++; if (to) begin n_err++; $display("FAIL mid_timeout: got no result_valid, expected one"); end
    n_vec++; if (longint'(bus.score) != model_score(1)) begin
      n_err++; $display("FAIL mid_fresh_score: got %0d, expected %0d", bus.score, model_score(1)); end
    n_vec++; if (bus.prediction !== 1'b0) begin n_err++; $display("FAIL mid_pred: got %b, expected 0", bus.prediction); end
    accept();
  endtask

  task automatic test_random();
    bit to;
    bit seq_ok;
    int n;
    longint exp_s, thr;
    for (int it = 0; it < 10; it++) begin
      eng_lat = $urandom_range(1, 5);
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) leaf_mem[i] = $urandom;
      exp_s = model_score(n);
      thr = exp_s + longint'($urandom_range(0, 20)) - 10;
      do_start(n, thr);
      wait_result(to);
      seq_ok = !to && (launch_log.size() == n);
      for (int i = 0; i < launch_log.size(); i++) if (launch_log[i] != i) seq_ok = 1'b0;
      n_vec++; if (!seq_ok) begin n_err++; $display("FAIL rnd_launches[%0d]: got %0d launches, expected %0d", it, launch_log.size(), n); end
      n_vec++; if (longint'(bus.score) != exp_s) begin
        n_err++; $display("FAIL rnd_score[%0d]: got %0d, expected %0d", it, bus.score, exp_s); end
      n_vec++; if (bus.prediction !== (exp_s >= thr)) begin
        n_err++; $display("FAIL rnd_pred[%0d]: got %b, expected %b", it, bus.prediction, exp_s >= thr); end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      accept();
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.n_trees      = '0;
    bus.threshold    = '0;
    bus.result_ready = 1'b0;
    for (int i = 0; i < int'(N_TREES); i++) leaf_mem[i] = '0;
    test_reset();
    test_basic();
    test_negative();
    test_zero();
    test_saturate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
